// File: rtl/cpu0_oci_dct_packer.sv
// rtl/cpu0_oci_dct_packer.sv - debug-trace frame packer with output word FIFO (optional CPU0_OCI_DCT_TIMESTAMP_EN adds word_ts)
module cpu0_oci_dct_packer #(
    parameter int FRAME_W         = 2,
    parameter int FRAMES_PER_WORD = 15,
    parameter int FIFO_DEPTH      = 8,
    localparam int WW = FRAME_W * FRAMES_PER_WORD,
    localparam int CW = $clog2(FRAMES_PER_WORD + 1),
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic          flush,
    input  logic          clr_ovf,
    input  logic          word_ready,
    output logic          word_valid,
    output logic [WW-1:0] word_data,
    output logic [CW-1:0] word_count,
    output logic [LW-1:0] fifo_level,
`ifdef CPU0_OCI_DCT_TIMESTAMP_EN
    output logic [15:0]   word_ts,
`endif
    output logic          overflow
);

    logic [WW-1:0] slots;
    logic [CW-1:0] cnt;
    logic [WW-1:0] fill_slots;
    logic [CW-1:0] fill_cnt;
    logic          push;

    logic [WW-1:0] mem_data [FIFO_DEPTH];
    logic [CW-1:0] mem_cnt  [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] level;
    logic          pop;
    logic          wr_en;
    logic          drop;

    // Slot image and frame count including this cycle's frame; decides whether a word leaves the packer now
    always_comb begin
        fill_slots = slots;
        fill_cnt   = cnt;
        if (frame_valid) begin
            for (int k = 0; k < FRAMES_PER_WORD; k++) begin
                if (cnt == CW'(k)) begin
                    fill_slots[k*FRAME_W +: FRAME_W] = frame_data;
                end
            end
            fill_cnt = cnt + CW'(1);
        end
        push = (fill_cnt == CW'(FRAMES_PER_WORD)) || (flush && (fill_cnt != '0));
    end

    // Packer state: restart at slot 0 with cleared slots whenever a word is handed to the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots <= '0;
            cnt   <= '0;
        end else if (push) begin
            slots <= '0;
            cnt   <= '0;
        end else begin
            slots <= fill_slots;
            cnt   <= fill_cnt;
        end
    end

    // A full FIFO still takes a word when the head leaves in the same cycle; otherwise the new word is dropped
    always_comb begin
        pop   = (level != '0) && word_ready;
        wr_en = push && ((level != LW'(FIFO_DEPTH)) || pop);
        drop  = push && !wr_en;
    end

    // Word storage; contents only matter while counted by level, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wptr] <= fill_slots;
            mem_cnt[wptr]  <= fill_cnt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (pop)   rptr <= rptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_ovf wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Head word presented only while the FIFO holds something, so outputs read zero when empty
    always_comb begin
        word_valid = (level != '0);
        word_data  = word_valid ? mem_data[rptr] : '0;
        word_count = word_valid ? mem_cnt[rptr]  : '0;
        fifo_level = level;
    end

`ifdef CPU0_OCI_DCT_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] held_ts;
    logic [15:0] fill_ts;
    logic [15:0] mem_ts [FIFO_DEPTH];

    // Timestamp of a word is the cycle counter when its slot 0 is filled
    always_comb begin
        fill_ts = (frame_valid && (cnt == '0)) ? ts_cnt : held_ts;
    end

    // Free-running cycle counter and the stamp of the word being packed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt  <= '0;
            held_ts <= '0;
        end else begin
            ts_cnt  <= ts_cnt + 16'd1;
            held_ts <= fill_ts;
        end
    end

    // Stamp travels through the FIFO next to its word
    always_ff @(posedge clk) begin
        if (wr_en) mem_ts[wptr] <= fill_ts;
    end

    // Head stamp, zero when empty
    always_comb begin
        word_ts = word_valid ? mem_ts[rptr] : '0;
    end
`endif

endmodule

// File: tb/tb_cpu0_oci_dct_packer.sv
// tb/tb_cpu0_oci_dct_packer.sv - directed self-checking bench for cpu0_oci_dct_packer
module tb_cpu0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic [1:0]  frame_data;
    logic        flush;
    logic        clr_ovf;
    logic        word_ready;
    logic        word_valid;
    logic [29:0] word_data;
    logic [3:0]  word_count;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef CPU0_OCI_DCT_TIMESTAMP_EN
    logic [15:0] word_ts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cpu0_oci_dct_packer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .flush       (flush),
        .clr_ovf     (clr_ovf),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_count  (word_count),
        .fifo_level  (fifo_level),
`ifdef CPU0_OCI_DCT_TIMESTAMP_EN
        .word_ts     (word_ts),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [29:0] drain_exp [8];
        drain_exp[0] = 30'd2; drain_exp[1] = 30'd3; drain_exp[2] = 30'd0; drain_exp[3] = 30'd1;
        drain_exp[4] = 30'd2; drain_exp[5] = 30'd3; drain_exp[6] = 30'd0; drain_exp[7] = 30'd2;

        reset = 1'b1; frame_valid = 1'b0; frame_data = 2'd0;
        flush = 1'b0; clr_ovf = 1'b0; word_ready = 1'b0;
        step(); step();
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_data",  32'(word_data),  32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);
        reset = 1'b0;

        // full word: frames 0,1,2,3,0,... packed LSB-first
        frame_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            frame_data = 2'(i % 4);
            step();
            if (i == 13) chk("full_not_yet", 32'(word_valid), 32'd0);
        end
        frame_valid = 1'b0;
        chk("full_valid", 32'(word_valid), 32'd1);
        chk("full_count", 32'(word_count), 32'd15);
        chk("full_data",  32'(word_data),  32'h24E4E4E4);
        chk("full_level", 32'(fifo_level), 32'd1);
        word_ready = 1'b1; step(); word_ready = 1'b0;
        chk("full_popped", 32'(fifo_level), 32'd0);

        // partial flush of 3,2,1 then flush with nothing held
        frame_valid = 1'b1;
        frame_data = 2'd3; step();
        frame_data = 2'd2; step();
        frame_data = 2'd1; step();
        frame_valid = 1'b0; flush = 1'b1; step();
        chk("part_count", 32'(word_count), 32'd3);
        chk("part_data",  32'(word_data),  32'h0000001B);
        chk("part_level", 32'(fifo_level), 32'd1);
        word_ready = 1'b1; step();
        flush = 1'b0; word_ready = 1'b0;
        chk("empty_flush_level", 32'(fifo_level), 32'd0);
        chk("empty_flush_valid", 32'(word_valid), 32'd0);

        // 15th frame coincides with flush
        frame_valid = 1'b1; frame_data = 2'd1;
        for (int i = 0; i < 14; i++) step();
        flush = 1'b1; step();
        frame_valid = 1'b0; flush = 1'b0;
        chk("coll_level", 32'(fifo_level), 32'd1);
        chk("coll_count", 32'(word_count), 32'd15);
        chk("coll_data",  32'(word_data),  32'h15555555);
        step();
        chk("coll_single", 32'(fifo_level), 32'd1);
        word_ready = 1'b1; step(); word_ready = 1'b0;
        chk("coll_popped", 32'(fifo_level), 32'd0);

        // overflow: 9 single-frame words with consumer stalled
        frame_valid = 1'b1; flush = 1'b1;
        for (int i = 0; i < 8; i++) begin
            frame_data = 2'((i + 1) % 4);
            step();
        end
        chk("ovf_level8",  32'(fifo_level), 32'd8);
        chk("ovf_not_yet", 32'(overflow),   32'd0);
        frame_data = 2'd3; step();
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_flag",  32'(overflow),   32'd1);
        chk("ovf_head",  32'(word_data),  32'd1);
        chk("ovf_headc", 32'(word_count), 32'd1);
        frame_valid = 1'b0; flush = 1'b0; clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("ovf_clr",       32'(overflow),   32'd0);
        chk("ovf_clr_level", 32'(fifo_level), 32'd8);

        // push and pop in the same cycle while full
        frame_valid = 1'b1; flush = 1'b1; frame_data = 2'd2; word_ready = 1'b1; step();
        frame_valid = 1'b0; flush = 1'b0;
        chk("pp_level", 32'(fifo_level), 32'd8);
        chk("pp_ovf",   32'(overflow),   32'd0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain_%0d", j), 32'(word_data), 32'(drain_exp[j]));
            step();
        end
        word_ready = 1'b0;
        chk("drain_level", 32'(fifo_level), 32'd0);

        // reset in the middle of a word with one word queued
        frame_valid = 1'b1; flush = 1'b1; frame_data = 2'd1; step(); flush = 1'b0;
        frame_data = 2'd3;
        for (int i = 0; i < 5; i++) step();
        frame_valid = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", 32'(fifo_level), 32'd0);
        chk("async_rst_valid", 32'(word_valid), 32'd0);
        chk("async_rst_data",  32'(word_data),  32'd0);
        step();
        reset = 1'b0;
        step();
        frame_valid = 1'b1; frame_data = 2'd2;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 9) chk("mid_rst_not_yet", 32'(word_valid), 32'd0);
        end
        frame_valid = 1'b0;
        chk("mid_rst_count", 32'(word_count), 32'd15);
        chk("mid_rst_data",  32'(word_data),  32'h2AAAAAAA);
        chk("mid_rst_level", 32'(fifo_level), 32'd1);
`ifdef CPU0_OCI_DCT_TIMESTAMP_EN
        chk("mid_rst_ts", 32'(word_ts), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
